// File: rtl/vehicle_sensor_conditioner_if.sv
// ----------------------------------------------------------------------------
// vehicle_sensor_conditioner_if
//
// Groups the loop-detector inputs, the light feedback from the traffic-light
// controller and the conditioned demand/fault outputs of
// vehicle_sensor_conditioner.
//
// Signals:
//   Loop1..Loop3  raw, asynchronous loop detector levels (NB, EB, WB)
//   L1..L3        current light per approach, fed back from fsm
//   S1..S3        conditioned demand per approach, to fsm
//   Fault         sticky stuck-loop flags, bit n-1 belongs to lane n
//
// Modports:
//   master  drives loops and lights, observes demand and fault (fsm side)
//   slave   the conditioner itself
// ----------------------------------------------------------------------------
interface vehicle_sensor_conditioner_if;

    logic       Loop1;
    logic       Loop2;
    logic       Loop3;
    logic [1:0] L1;
    logic [1:0] L2;
    logic [1:0] L3;
    logic       S1;
    logic       S2;
    logic       S3;
    logic [2:0] Fault;

    modport master (
        output Loop1, Loop2, Loop3,
        output L1, L2, L3,
        input  S1, S2, S3,
        input  Fault
    );

    modport slave (
        input  Loop1, Loop2, Loop3,
        input  L1, L2, L3,
        output S1, S2, S3,
        output Fault
    );

endinterface

// File: rtl/vehicle_sensor_conditioner.sv
// ----------------------------------------------------------------------------
// vehicle_sensor_conditioner
//
// Turns the three raw vehicle-loop inputs into clean demand signals S1..S3
// for the traffic-light fsm. Each lane independently:
//   - synchronises its asynchronous loop input through two flops,
//   - debounces the synchronised level (DEBOUNCE consecutive samples),
//   - optionally latches a call that is held until its approach shows GREEN,
//   - flags a loop that stays on for STUCK_LIMIT cycles; a faulted lane
//     presents permanent demand until Reset.
//
// Ports:
//   Clock  single clock, all logic on posedge
//   Reset  synchronous, active-low; clears every register
//   bus    vehicle_sensor_conditioner_if.slave
//            Loop1..3 in, L1..3 in, S1..3 out (registered), Fault[2:0] out
//
// Build option:
//   SENSOR_CALL_LATCH_EN  when defined, the call latch is built and
//                         Sn = db | call | Fault[n-1]; when undefined the
//                         call is constant 0 and Sn = db | Fault[n-1].
//
// No input reaches an output without passing through a register.
// ----------------------------------------------------------------------------
module vehicle_sensor_conditioner #(
    parameter int unsigned DEBOUNCE    = 4,
    parameter int unsigned STUCK_LIMIT = 1000,
    parameter logic [1:0]  GREEN       = 2'b01,
    parameter logic [1:0]  YELLOW      = 2'b10,
    parameter logic [1:0]  RED         = 2'b11
) (
    input logic                         Clock,
    input logic                         Reset,
    vehicle_sensor_conditioner_if.slave bus
);

    localparam int unsigned NumLanes = 3;
    localparam int unsigned CntW     = $clog2(DEBOUNCE);
    localparam int unsigned StkW     = $clog2(STUCK_LIMIT + 1);

    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE - 1);
    localparam logic [StkW-1:0] StkMax = StkW'(STUCK_LIMIT);

    // ------------------------------------------------------------------------
    // Lane-indexed views of the interface
    // ------------------------------------------------------------------------
    logic [NumLanes-1:0] loop_raw;

    assign loop_raw = {bus.Loop3, bus.Loop2, bus.Loop1};

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [NumLanes-1:0] sync1_q;
    logic [NumLanes-1:0] sync2_q;
    logic [NumLanes-1:0] db_q;
    logic [NumLanes-1:0] db_d;
    logic [NumLanes-1:0] db_rise;
    logic [CntW-1:0]     cnt_q [NumLanes];
    logic [CntW-1:0]     cnt_d [NumLanes];
    logic [StkW-1:0]     stk_q [NumLanes];
    logic [StkW-1:0]     stk_d [NumLanes];
    logic [NumLanes-1:0] fault_q;
    logic [NumLanes-1:0] fault_d;
    logic [NumLanes-1:0] s_q;
    logic [NumLanes-1:0] s_d;
    logic [NumLanes-1:0] call;

    // ------------------------------------------------------------------------
    // Debouncer and stuck detector next state
    // ------------------------------------------------------------------------
    always_comb begin
        db_d    = db_q;
        db_rise = '0;
        fault_d = fault_q;
        for (int i = 0; i < NumLanes; i++) begin
            cnt_d[i] = '0;
            stk_d[i] = stk_q[i];

            // A disagreement run must last DEBOUNCE samples; any agreeing
            // sample in between restarts the count from zero.
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    db_d[i]    = sync2_q[i];
                    db_rise[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end

            // Count consecutive debounced-high cycles, saturating.
            if (!db_q[i]) begin
                stk_d[i] = '0;
            end else if (stk_q[i] != StkMax) begin
                stk_d[i] = stk_q[i] + 1'b1;
            end

            // Sticky: set on the cycle the count reaches the limit.
            if (stk_d[i] == StkMax) begin
                fault_d[i] = 1'b1;
            end
        end
    end

`ifdef SENSOR_CALL_LATCH_EN
    // ------------------------------------------------------------------------
    // Call latch: set on debounced rise, cleared when the approach is served.
    // ------------------------------------------------------------------------
    logic [1:0]          light [NumLanes];
    logic [NumLanes-1:0] served;
    logic [NumLanes-1:0] call_q;
    logic [NumLanes-1:0] call_d;

    assign light[0] = bus.L1;
    assign light[1] = bus.L2;
    assign light[2] = bus.L3;

    always_comb begin
        served = '0;
        call_d = '0;
        for (int i = 0; i < NumLanes; i++) begin
            // Only GREEN serves the approach; 2'b00 is treated as not served.
            case (light[i])
                GREEN:       served[i] = 1'b1;
                YELLOW, RED: served[i] = 1'b0;
                default:     served[i] = 1'b0;
            endcase
            // Set has priority over a coincident clear.
            call_d[i] = db_rise[i] | (call_q[i] & ~served[i]);
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            call_q <= '0;
        end else begin
            call_q <= call_d;
        end
    end

    assign call = call_q;
`else
    // Without the latch the light feedback has no consumer; the ports stay
    // so both builds present the same interface.
    logic unused_light;

    assign unused_light = ^{bus.L1, bus.L2, bus.L3, db_rise};
    assign call         = '0;
`endif

    // ------------------------------------------------------------------------
    // Registered demand
    // ------------------------------------------------------------------------
    always_comb begin
        s_d = db_q | call | fault_q;
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            cnt_q   <= '{default: '0};
            stk_q   <= '{default: '0};
            fault_q <= '0;
            s_q     <= '0;
        end else begin
            sync1_q <= loop_raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            stk_q   <= stk_d;
            fault_q <= fault_d;
            s_q     <= s_d;
        end
    end

    assign bus.S1    = s_q[0];
    assign bus.S2    = s_q[1];
    assign bus.S3    = s_q[2];
    assign bus.Fault = fault_q;

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// ----------------------------------------------------------------------------
// tb_vehicle_sensor_conditioner
//
// Directed stimulus for vehicle_sensor_conditioner (DEBOUNCE = 4,
// STUCK_LIMIT = 20). The driver pushes hand-computed expectations, tagged
// with the clock edge they apply to, into a scoreboard queue; a monitor on
// the falling edge pops every entry that is due and compares {S3,S2,S1} and
// Fault. Expectations depend on whether SENSOR_CALL_LATCH_EN is defined.
// ----------------------------------------------------------------------------
module tb_vehicle_sensor_conditioner;

    localparam int unsigned DEBOUNCE    = 4;
    localparam int unsigned STUCK_LIMIT = 20;
    localparam logic [1:0]  GREEN       = 2'b01;
    localparam logic [1:0]  RED         = 2'b11;

`ifdef SENSOR_CALL_LATCH_EN
    localparam bit CallEn = 1'b1;
`else
    localparam bit CallEn = 1'b0;
`endif

    bit   Clock;
    logic Reset;

    vehicle_sensor_conditioner_if bus ();

    vehicle_sensor_conditioner #(
        .DEBOUNCE   (DEBOUNCE),
        .STUCK_LIMIT(STUCK_LIMIT)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clock = ~Clock;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        int         edge_n;
        logic [2:0] s;
        logic [2:0] f;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   mi;
    int   now;

    task automatic expect_range(input int a, input int b, input logic [2:0] s,
                                input logic [2:0] f, input string name);
        exp_t x;
        for (int e = a; e <= b; e++) begin
            x.edge_n = e;
            x.s      = s;
            x.f      = f;
            x.name   = name;
            sb.push_back(x);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clock);
    endtask

    // Monitor: compare every expectation whose edge has passed.
    always @(negedge Clock) begin
        mi = 0;
        while (mi < sb.size()) begin
            if (sb[mi].edge_n <= cyc) begin
                vectors++;
                if ({bus.S3, bus.S2, bus.S1} !== sb[mi].s || bus.Fault !== sb[mi].f) begin
                    miscompares++;
                    $display("FAIL %s edge %0d: got S=%b Fault=%b, want S=%b Fault=%b",
                             sb[mi].name, sb[mi].edge_n, {bus.S3, bus.S2, bus.S1},
                             bus.Fault, sb[mi].s, sb[mi].f);
                end
                sb.delete(mi);
            end else begin
                mi++;
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: run did not complete, got time %0t, want < 50000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        Reset     = 1'b0;
        bus.Loop1 = 1'b0;
        bus.Loop2 = 1'b0;
        bus.Loop3 = 1'b0;
        bus.L1    = RED;
        bus.L2    = RED;
        bus.L3    = RED;

        // Reset held for two edges.
        expect_range(1, 2, 3'b000, 3'b000, "reset");
        step(2);
        vectors++;
        if ({bus.S3, bus.S2, bus.S1} !== 3'b000 || bus.Fault !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_direct: got S=%b Fault=%b, want S=000 Fault=000",
                     {bus.S3, bus.S2, bus.S1}, bus.Fault);
        end
        Reset = 1'b1;

        // Three-cycle glitch on Loop1 is discarded.
        now = cyc;
        expect_range(now + 1, now + 9, 3'b000, 3'b000, "glitch");
        bus.Loop1 = 1'b1;
        step(3);
        bus.Loop1 = 1'b0;
        step(6);
        vectors++;
        if ({bus.S3, bus.S2, bus.S1} !== 3'b000 || bus.Fault !== 3'b000) begin
            miscompares++;
            $display("FAIL glitch_direct: got S=%b Fault=%b, want S=000 Fault=000",
                     {bus.S3, bus.S2, bus.S1}, bus.Fault);
        end

        // Debounce latency on lane 2 (GREEN keeps the call out of the way).
        now = cyc;
        expect_range(now + 1, now + 6, 3'b000, 3'b000, "latency_pre");
        expect_range(now + 7, now + 14, 3'b010, 3'b000, "latency_hi");
        expect_range(now + 15, now + 17, 3'b000, 3'b000, "release");
        bus.L2    = GREEN;
        bus.Loop2 = 1'b1;
        step(8);
        vectors++;
        if ({bus.S3, bus.S2, bus.S1} !== 3'b010 || bus.Fault !== 3'b000) begin
            miscompares++;
            $display("FAIL latency_direct: got S=%b Fault=%b, want S=010 Fault=000",
                     {bus.S3, bus.S2, bus.S1}, bus.Fault);
        end
        bus.Loop2 = 1'b0;
        step(9);
        bus.L2 = RED;

        // Call latch on lane 1 with L1 = RED, then served by GREEN.
        now = cyc;
        expect_range(now + 1, now + 6, 3'b000, 3'b000, "call_pre");
        expect_range(now + 7, now + 16, 3'b001, 3'b000, "call_db");
        if (CallEn) begin
            expect_range(now + 17, now + 21, 3'b001, 3'b000, "call_hold");
            expect_range(now + 22, now + 24, 3'b000, 3'b000, "call_clear");
        end else begin
            expect_range(now + 17, now + 24, 3'b000, 3'b000, "nocall_drop");
        end
        bus.Loop1 = 1'b1;
        step(10);
        bus.Loop1 = 1'b0;
        step(10);
        bus.L1 = GREEN;
        step(1);
        bus.L1 = RED;
        step(4);

        // Lane 3: db rise coincides with sampled GREEN; set wins.
        now = cyc;
        expect_range(now + 1, now + 6, 3'b000, 3'b000, "setclr_pre");
        expect_range(now + 7, now + 14, 3'b100, 3'b000, "setclr_db");
        if (CallEn) begin
            expect_range(now + 15, now + 19, 3'b100, 3'b000, "setclr_hold");
            expect_range(now + 20, now + 22, 3'b000, 3'b000, "setclr_clear");
        end else begin
            expect_range(now + 15, now + 22, 3'b000, 3'b000, "setclr_drop");
        end
        bus.Loop3 = 1'b1;
        step(5);
        bus.L3 = GREEN;
        step(1);
        bus.L3 = RED;
        step(2);
        bus.Loop3 = 1'b0;
        step(10);
        bus.L3 = GREEN;
        step(1);
        bus.L3 = RED;
        step(4);

        // Stuck loop on lane 3, then Reset clears the sticky fault.
        now = cyc;
        expect_range(now + 1, now + 6, 3'b000, 3'b000, "stuck_pre");
        expect_range(now + 7, now + 25, 3'b100, 3'b000, "stuck_count");
        expect_range(now + 26, now + 45, 3'b100, 3'b100, "stuck_fault");
        expect_range(now + 46, now + 47, 3'b000, 3'b000, "stuck_reset");
        bus.Loop3 = 1'b1;
        step(30);
        bus.Loop3 = 1'b0;
        step(10);
        bus.L3 = GREEN;
        step(1);
        bus.L3 = RED;
        step(4);
        Reset = 1'b0;
        step(2);
        Reset = 1'b1;

        // Reset while the lane-2 debounce count is 3; full latency afterwards.
        now = cyc;
        expect_range(now + 1, now + 12, 3'b000, 3'b000, "midreset_lo");
        expect_range(now + 13, now + 15, 3'b010, 3'b000, "midreset_hi");
        bus.Loop2 = 1'b1;
        step(5);
        Reset = 1'b0;
        step(1);
        Reset = 1'b1;
        step(8);
        bus.Loop2 = 1'b0;
        step(4);

        // Any expectation still queued was never reached.
        while (sb.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s edge %0d: got no check by edge %0d, want checked",
                     sb[0].name, sb[0].edge_n, cyc);
            void'(sb.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
